// File: rtl/uart_xcvr.sv
// Full-duplex UART: TX with valid/ready handshake, RX with start-glitch rejection,
// parity check and framing flag. TX and RX share only the clock and reset.
module uart_xcvr #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUDRATE  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int BIT_PERIOD = CLK_FREQ / BAUDRATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] MID   = CW'(HALF - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- transmitter ----------------
  state_t                tx_state, tx_next;
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;
  logic [DATA_BITS-1:0]  tx_shift, tx_shift_n;
  logic                  tx_par, tx_line, tx_accept, tx_bit_end;

  assign tx_accept  = tx_valid && tx_ready;
  assign tx_bit_end = (tx_cnt == LAST);

  always_comb begin
    tx_next    = tx_state;
    tx_shift_n = tx_shift;
    tx_line    = 1'b1;
    case (tx_state)
      S_IDLE:   if (tx_accept) begin
                  tx_next    = S_START;
                  tx_shift_n = tx_data;
                end
      S_START:  if (tx_bit_end) tx_next = S_DATA;
      S_DATA:   if (tx_bit_end) begin
                  tx_shift_n = tx_shift >> 1;
                  if (tx_bit == DLAST) tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
      S_PARITY: if (tx_bit_end) tx_next = S_STOP;
      S_STOP:   if (tx_bit_end && tx_bit == SLAST) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
    // line level is derived from the upcoming state so tx is a clean register
    case (tx_next)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift_n[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx       <= tx_line;
      tx_ready <= (tx_next == S_IDLE);
      if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + 1'b1;
      if (tx_next != tx_state) tx_bit <= '0;
      else if (tx_bit_end)     tx_bit <= tx_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_n;
    if (tx_accept) tx_par <= parity_of(tx_data);
  end

  // ---------------- receiver ----------------
  state_t                rx_state, rx_next;
  logic                  rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]         rx_cnt;
  logic [3:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par_bad, rx_fall, rx_tick, rx_done;

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_tick = (rx_cnt == LAST);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_next = S_START;
      S_START:  if (rx_cnt == MID) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_bit == DLAST) rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_next = S_STOP;
      S_STOP:   if (rx_tick) begin
                  rx_next = S_IDLE;
                  rx_done = 1'b1;
                end
      default:  rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      rx_valid <= rx_done;
      if (rx_next != rx_state || rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
      else                                                      rx_cnt <= rx_cnt + 1'b1;
      if (rx_next != rx_state) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + 1'b1;
      if (rx_state == S_IDLE) rx_par_bad <= 1'b0;
      else if (rx_state == S_PARITY && rx_tick) rx_par_bad <= rx_s2 ^ parity_of(rx_shift);
      // stop bit is sampled once; the rest of it is left to the idle edge detector
      if (rx_done) begin
        rx_data       <= rx_shift;
        rx_frame_err  <= !rx_s2;
        rx_parity_err <= rx_par_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboarded bench for uart_xcvr: four instances cover 8N1, 8E1 loopback,
// 8O1 receive and 7N2 loopback with a mid-frame reset.
module tb_uart_xcvr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] tx_valid_v;
  logic       rx_line;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  logic ready_n, tx_n, rxv_n, pe_n, fe_n; logic [7:0] rxd_n;
  logic ready_e, tx_e, rxv_e, pe_e, fe_e; logic [7:0] rxd_e;
  logic ready_o, tx_o, rxv_o, pe_o, fe_o; logic [7:0] rxd_o;
  logic ready_7, tx_7, rxv_7, pe_7, fe_7; logic [6:0] rxd_7;
  logic rx_n_in, rx_o_in, tx_sel, ready_sel;

  assign rx_n_in = (sel == 0) ? rx_line : 1'b1;
  assign rx_o_in = (sel == 2) ? rx_line : 1'b1;

  always_comb begin
    tx_sel    = 1'b1;
    ready_sel = 1'b1;
    case (sel)
      0: begin tx_sel = tx_n; ready_sel = ready_n; end
      1: begin tx_sel = tx_e; ready_sel = ready_e; end
      2: begin tx_sel = tx_o; ready_sel = ready_o; end
      3: begin tx_sel = tx_7; ready_sel = ready_7; end
      default: begin tx_sel = 1'b1; ready_sel = 1'b1; end
    endcase
  end

  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid_v[0]), .tx_ready(ready_n), .tx(tx_n),
    .rx(rx_n_in), .rx_data(rxd_n), .rx_valid(rxv_n), .rx_parity_err(pe_n), .rx_frame_err(fe_n));
  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid_v[1]), .tx_ready(ready_e), .tx(tx_e),
    .rx(tx_e), .rx_data(rxd_e), .rx_valid(rxv_e), .rx_parity_err(pe_e), .rx_frame_err(fe_e));
  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid_v[2]), .tx_ready(ready_o), .tx(tx_o),
    .rx(rx_o_in), .rx_data(rxd_o), .rx_valid(rxv_o), .rx_parity_err(pe_o), .rx_frame_err(fe_o));
  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7 (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(tx_valid_v[3]), .tx_ready(ready_7), .tx(tx_7),
    .rx(tx_7), .rx_data(rxd_7), .rx_valid(rxv_7), .rx_parity_err(pe_7), .rx_frame_err(fe_7));

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line image of one frame, bit 0 = start bit; unused upper bits stay idle-high.
  function automatic logic [15:0] frame(input logic [8:0] d, input int nb, input int par,
                                        input bit bad_par, input bit bad_stop);
    logic [15:0] f;
    logic        p;
    int          idx;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      p      = p ^ d[i];
    end
    idx = 1 + nb;
    if (par != 0) begin
      f[idx] = ((par == 1) ? ~p : p) ^ bad_par;
      idx++;
    end
    if (bad_stop) f[idx] = 1'b0;
    return f;
  endfunction

  function automatic int flen(input int nb, input int par, input int st);
    return 1 + nb + ((par != 0) ? 1 : 0) + st;
  endfunction

  task automatic drive_frame(input logic [15:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      rx_line = f[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic push_exp(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.id = id; e.data = d; e.perr = pe; e.ferr = fe;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    check("rx_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rx_inst", id, e.id);
      check("rx_data", d, e.data);
      check("rx_perr", pe, e.perr);
      check("rx_ferr", fe, e.ferr);
    end
  endtask

  always @(negedge clk) begin
    if (rxv_n) pop_cmp(0, {1'b0, rxd_n}, pe_n, fe_n);
    if (rxv_e) pop_cmp(1, {1'b0, rxd_e}, pe_e, fe_e);
    if (rxv_o) pop_cmp(2, {1'b0, rxd_o}, pe_o, fe_o);
    if (rxv_7) pop_cmp(3, {2'b00, rxd_7}, pe_7, fe_7);
  end

  // Accept at one edge, then check every line cycle and the return of tx_ready.
  task automatic send_watch(input int s, input logic [7:0] d, input int nb, input int par,
                            input int st, input int ignore_at);
    logic [15:0] f;
    int          len;
    f   = frame({1'b0, d}, nb, par, 1'b0, 1'b0);
    len = flen(nb, par, st);
    sel = s;
    @(negedge clk);
    tx_data       = d;
    tx_valid_v[s] = 1'b1;
    for (int k = 1; k <= len * 10; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid_v = '0;
      check("tx_line", tx_sel, f[(k-1)/10]);
      check("tx_busy", ready_sel, 0);
      if (k == ignore_at) begin
        tx_data       = ~d;
        tx_valid_v[s] = 1'b1;
      end
      if (k == ignore_at + 1) tx_valid_v = '0;
    end
    @(negedge clk);
    check("tx_ready_back", ready_sel, 1);
    check("tx_idle", tx_sel, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_data = '0; tx_valid_v = '0; rx_line = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_n, 1);
    check("rst_ready", ready_n, 1);
    check("rst_rxd", rxd_n, 0);
    check("rst_rxv", rxv_n, 0);
    check("rst_perr", pe_n, 0);
    check("rst_ferr", fe_n, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_watch(0, 8'hA5, 8, 0, 1, 30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("tx_ignored_req", tx_n, 1);
    end

    push_exp(1, 9'h03C, 1'b0, 1'b0);
    send_watch(1, 8'h3C, 8, 2, 1, 0);
    repeat (20) @(negedge clk);

    sel = 2;
    repeat (5) @(negedge clk);
    push_exp(2, 9'h001, 1'b1, 1'b0);
    drive_frame(frame(9'h001, 8, 1, 1'b1, 1'b0), 11);
    rx_line = 1'b1;
    repeat (10) @(negedge clk);
    check("perr_hold", pe_o, 1);
    push_exp(2, 9'h002, 1'b0, 1'b0);
    drive_frame(frame(9'h002, 8, 1, 1'b0, 1'b0), 11);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check("perr_cleared", pe_o, 0);

    sel = 0;
    repeat (5) @(negedge clk);
    push_exp(0, 9'h055, 1'b0, 1'b1);
    drive_frame(frame(9'h055, 8, 0, 1'b0, 1'b1), 10);
    rx_line = 1'b0;
    repeat (30) @(negedge clk);
    check("ferr_hold", fe_n, 1);
    rx_line = 1'b1;
    repeat (15) @(negedge clk);
    push_exp(0, 9'h0C3, 1'b0, 1'b0);
    drive_frame(frame(9'h0C3, 8, 0, 1'b0, 1'b0), 10);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_cleared", fe_n, 0);

    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (7) @(negedge clk);
    push_exp(0, 9'h096, 1'b0, 1'b0);
    drive_frame(frame(9'h096, 8, 0, 1'b0, 1'b0), 10);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);

    push_exp(3, 9'h07F, 1'b0, 1'b0);
    send_watch(3, 8'h7F, 7, 0, 2, 0);
    repeat (10) @(negedge clk);
    tx_data       = 8'h2A;
    tx_valid_v[3] = 1'b1;
    @(negedge clk);
    tx_valid_v = '0;
    repeat (34) @(negedge clk);
    check("busy_before_rst", ready_7, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx_7, 1);
    check("abort_ready", ready_7, 1);
    check("abort_rxd", rxd_7, 0);
    check("abort_rxv", rxv_7, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_line_idle", tx_7, 1);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
Parametrised full-duplex UART transceiver. Configurable data width, parity mode and stop-bit count. TX side has a valid/ready handshake. RX side has start-bit glitch rejection, parity checking and framing-error flags. Used as the standard serial front end in place of hand-coded per-design UART logic; sits between the board rx/tx pins and the user datapath.

Parameters:
CLK_FREQ, 50_000_000, main clock frequency in Hz
BAUDRATE, 115200, line rate in bit/s; BIT_PERIOD = CLK_FREQ/BAUDRATE (integer division), HALF = BIT_PERIOD/2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits transmitted; 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_data  in  DATA_BITS  byte to send, LSB first
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle and able to accept
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  last received word
rx_valid  out  1  one-cycle pulse when rx_data is updated
rx_parity_err  out  1  parity mismatch for the frame; qualified by rx_valid
rx_frame_err  out  1  first stop bit sampled low; qualified by rx_valid

Behaviour:
- Single clock. rst is sampled on the clk rising edge.
- Reset values: tx=1, tx_ready=1, rx_data=0, rx_valid=0, both error flags=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame immediately. No partial rx_valid is produced. tx returns to 1 at the reset edge.
- Baud counter: counts 0..BIT_PERIOD-1, width $clog2(BIT_PERIOD). Each bit lasts exactly BIT_PERIOD cycles.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1 (registered, equal to state==IDLE). On tx_valid&&tx_ready, tx_data is latched into a shift register and the FSM moves to START.
  - tx is a registered output. It goes low on the cycle after the accepting edge (latency 1).
  - START: one bit period at 0.
  - DATA: DATA_BITS periods, LSB first.
  - PARITY: one period, skipped when PARITY=0. Odd: bit = ~^data. Even: bit = ^data.
  - STOP: STOP_BITS*BIT_PERIOD cycles at 1, then IDLE.
  - tx_ready is 0 from the accepting edge through the last stop cycle.
  - Back-to-back sends leave at most one idle cycle between frames.
  - tx_valid while tx_ready=0 is ignored; tx_data is don't-care then.
- RX front end: 2-flop synchroniser on rx, reset to 1, plus a previous-sample register. A start edge is synced 1 then 0.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a start edge moves the FSM to START with the counter at 0.
  - START: at count HALF-1 the synced line is rechecked. If high, it is a glitch: return to IDLE with no outputs. If low, continue.
  - Sampling points: each subsequent bit is sampled at the mid-bit point, i.e. every BIT_PERIOD cycles after the start check.
  - DATA: shifts DATA_BITS samples in LSB first.
  - PARITY: samples the parity bit when PARITY≠0, otherwise skipped. Mismatch against the configured parity of the received data sets the parity error.
  - STOP: samples the first stop bit only; a low sample means framing error. On that sampling cycle, next edge: rx_data <= shift register, rx_valid=1 for one cycle, both flags updated, FSM returns to IDLE.
  - The receiver does not wait out the rest of the stop bit. It resynchronises on the next falling edge.
  - A line held low (break) produces no new frame until rx rises and falls again.
- Error flags hold their value until the next rx_valid. rx_data is updated even on error.
- TX and RX are fully independent; simultaneous activity is allowed.

Test Plan:
(All with CLK_FREQ=1_000_000, BAUDRATE=100_000, so BIT_PERIOD=10 and HALF=5.)
- TX 8N1: tx_data=0xA5 with tx_valid accepted at edge 0 -> tx=0 in cycles 1-10; data bits 1,0,1,0,0,1,0,1 in 10-cycle slots over cycles 11-90; tx=1 in cycles 91-100; tx_ready=1 at cycle 101; a second tx_valid during the frame is ignored.
- Loopback tx->rx, PARITY=2: send 0x3C -> parity bit 0 on the line; a single rx_valid pulse with rx_data=0x3C and both error flags 0.
- PARITY=1: drive a frame with data 0x01 and parity bit 1 (wrong) -> rx_valid with rx_data=0x01 and rx_parity_err=1; the next correct frame clears the flag.
- Framing: 8N1 frame 0x55 with the stop bit driven 0 -> rx_valid with rx_frame_err=1; rx then held low for 30 cycles -> no further rx_valid; rx high then a valid frame -> received correctly.
- Glitch: rx low for 3 cycles, then high -> no rx_valid, and the RX FSM is back in IDLE by cycle 8; a following valid frame is received.
- Config DATA_BITS=7, STOP_BITS=2, plus reset: send 0x7F -> stop high for 20 cycles and tx_ready returns after 20+70+10+1 cycles; then rst asserted mid-DATA -> tx=1 and tx_ready=1 after that edge, rx_valid never pulses.
